// File: rtl/spi_flash_reader.sv
// Reads one 32-bit little-endian word from SPI flash (command 0x03) by driving
// an APB-attached SPI peripheral: select CS, hold CS, push 8 TX bytes, pull
// 8 RX bytes, release CS, then present the word on a valid/ready response port.
module spi_flash_reader #(
  parameter int unsigned CS_ID    = 0,
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        ReqValid,
  input  logic [23:0] ReqAddr,
  output logic        ReqReady,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 8;
  localparam int unsigned PCW = 10;
  localparam int unsigned BCW = 3;

  localparam logic [OW-1:0]  OFF_CSID = 8'h10;
  localparam logic [OW-1:0]  OFF_CTRL = 8'h18;
  localparam logic [OW-1:0]  OFF_TX   = 8'h48;
  localparam logic [OW-1:0]  OFF_RX   = 8'h4C;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
  localparam logic [BCW-1:0] BYTE_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_SETCS, S_HOLD, S_TXPOLL, S_TXWR, S_RXPOLL, S_RELEASE, S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic           pwrite_q, pwrite_d;
  logic [OW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;

  logic           xfer_done_c;
  logic           busy_c;
  logic           timeout_c;
  logic           accept_c;
  logic [7:0]     tx_byte_c;
  logic           prdata_unused_c;

  assign xfer_done_c     = psel_q & penable_q & PREADY;
  assign busy_c          = PRDATA[31];
  assign timeout_c       = (poll_cnt_q == POLL_LAST);
  assign accept_c        = ReqValid & req_ready_q;
  assign prdata_unused_c = ^PRDATA[30:8];

  assign ReqReady = req_ready_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PSTRB    = 4'hF;

  // Transmit byte for the current index: read command, 3 address bytes, 4 dummies
  always_comb begin
    tx_byte_c = 8'h00;
    case (byte_cnt_q)
      3'd0:    tx_byte_c = 8'h03;
      3'd1:    tx_byte_c = addr_q[23:16];
      3'd2:    tx_byte_c = addr_q[15:8];
      3'd3:    tx_byte_c = addr_q[7:0];
      default: tx_byte_c = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; transfer states advance only on a completed APB access
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept_c) state_d = S_SETCS;
      S_SETCS:   if (xfer_done_c) state_d = S_HOLD;
      S_HOLD:    if (xfer_done_c) state_d = S_TXPOLL;
      S_TXPOLL: begin
        if (xfer_done_c) begin
          if (!busy_c)        state_d = S_TXWR;
          else if (timeout_c) state_d = S_RELEASE;
        end
      end
      S_TXWR: begin
        if (xfer_done_c) state_d = (byte_cnt_q == BYTE_LAST) ? S_RXPOLL : S_TXPOLL;
      end
      S_RXPOLL: begin
        if (xfer_done_c) begin
          if (busy_c) begin
            if (timeout_c) state_d = S_RELEASE;
          end else if (byte_cnt_q == BYTE_LAST) begin
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: if (xfer_done_c) state_d = S_RESP;
      S_RESP:    if (rsp_valid_q && RspReady) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: APB setup/access/idle sequencing plus counters
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);

    if (state_q != S_IDLE && state_q != S_RESP) begin
      if (!psel_q) begin
        // Setup phase; PSEL was low last cycle so an idle gap is guaranteed
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwdata_d  = '0;
        case (state_q)
          S_SETCS:  begin pwrite_d = 1'b1; paddr_d = OFF_CSID; pwdata_d = DW'(CS_ID); end
          S_HOLD:   begin pwrite_d = 1'b1; paddr_d = OFF_CTRL; pwdata_d = DW'(2); end
          S_TXPOLL: begin pwrite_d = 1'b0; paddr_d = OFF_TX; end
          S_TXWR:   begin pwrite_d = 1'b1; paddr_d = OFF_TX; pwdata_d = DW'(tx_byte_c); end
          S_RXPOLL: begin pwrite_d = 1'b0; paddr_d = OFF_RX; end
          default:  begin pwrite_d = 1'b1; paddr_d = OFF_CTRL; end
        endcase
      end else if (!penable_q) begin
        penable_d = 1'b1;
      end else if (PREADY) begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          addr_d     = ReqAddr;
          byte_cnt_d = '0;
          poll_cnt_d = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      S_TXPOLL: begin
        if (xfer_done_c && busy_c) begin
          if (timeout_c) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
          end
        end
      end
      S_TXWR: begin
        if (xfer_done_c) begin
          poll_cnt_d = '0;
          byte_cnt_d = byte_cnt_q + BCW'(1);
        end
      end
      S_RXPOLL: begin
        if (xfer_done_c) begin
          if (busy_c) begin
            if (timeout_c) begin
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
            end else begin
              poll_cnt_d = poll_cnt_q + PCW'(1);
            end
          end else begin
            poll_cnt_d = '0;
            byte_cnt_d = byte_cnt_q + BCW'(1);
            case (byte_cnt_q)
              3'd4:    rsp_data_d[7:0]   = PRDATA[7:0];
              3'd5:    rsp_data_d[15:8]  = PRDATA[7:0];
              3'd6:    rsp_data_d[23:16] = PRDATA[7:0];
              3'd7:    rsp_data_d[31:24] = PRDATA[7:0];
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      byte_cnt_q  <= '0;
      poll_cnt_q  <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: APB slave model of the SPI peripheral, expected
// APB transfer stream per read kept in a queue, response checks per vector.
module tb_spi_flash_reader;

  localparam int unsigned CS_ID    = 2;
  localparam int unsigned POLL_MAX = 1023;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        ReqValid = 1'b0;
  logic [23:0] ReqAddr = '0;
  logic        ReqReady;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] RspData;
  logic        RspErr;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = 32'hDEAD_BEEF;

  spi_flash_reader #(.CS_ID(CS_ID), .POLL_MAX(POLL_MAX)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [23:0] addr;
    logic [63:0] rx;
    int          full_polls;
    bit          rx_dead;
    int          waits;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  xfer_t       sb_q[$];
  vec_t        vecs[6];

  // slave model state
  bit          mon_en = 1'b0;
  int          cur_waits = 0;
  int          full_left = 0;
  int          tx_wr_cnt = 0;
  int          rx_idx = 0;
  logic [63:0] cur_rx = '0;
  bit          rx_dead = 1'b0;
  logic [7:0]  s_addr;
  logic        s_wr;
  logic [31:0] s_data;
  bit          prev_psel = 1'b0;
  int          wait_cnt = 0;
  bit          stab_err = 1'b0;
  bit          gap_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave response for the access completing now, then scoreboard compare
  task automatic complete_xfer();
    xfer_t       e;
    logic [31:0] rd;
    logic [63:0] rxw;
    rd  = 32'h0000_0055;
    rxw = cur_rx >> (8 * (rx_idx & 7));
    if (!PWRITE && PADDR == 8'h48) begin
      if (tx_wr_cnt == 3 && full_left > 0) begin
        rd = 32'h8000_0055;
        full_left--;
      end
    end else if (!PWRITE && PADDR == 8'h4C) begin
      if (rx_dead) rd = 32'h8000_0000;
      else begin
        rd = 32'h7FFF_FF00 | {24'h0, rxw[7:0]};
        rx_idx++;
      end
    end else if (PWRITE && PADDR == 8'h48) begin
      tx_wr_cnt++;
    end
    PRDATA = rd;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        chk("xfer_unexpected", {23'h0, PWRITE, PADDR}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("xfer_kind", {23'h0, PWRITE, PADDR}, {23'h0, e.wr, e.addr});
        if (e.wr) chk("xfer_wdata", PWDATA, e.data);
      end
      chk("xfer_stable_gap", {30'h0, stab_err, gap_err}, 32'h0);
    end
  endtask

  // APB slave: decides PREADY/PRDATA on the falling edge for the next rising edge
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      s_addr   = PADDR;
      s_wr     = PWRITE;
      s_data   = PWDATA;
      stab_err = 1'b0;
      gap_err  = prev_psel;
      wait_cnt = 0;
      PREADY   = 1'b0;
      PRDATA   = 32'hDEAD_BEEF;
    end else if (PSEL && PENABLE) begin
      if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_data) stab_err = 1'b1;
      if (wait_cnt < cur_waits) begin
        wait_cnt++;
        PREADY = 1'b0;
        PRDATA = 32'hDEAD_BEEF;
      end else begin
        PREADY = 1'b1;
        complete_xfer();
      end
    end else begin
      PREADY = 1'b0;
      PRDATA = 32'hDEAD_BEEF;
    end
    prev_psel = PSEL;
  end

  task automatic push(input logic wr, input logic [7:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = wr;
    x.addr = a;
    x.data = d;
    sb_q.push_back(x);
  endtask

  task automatic build_expect(input vec_t v);
    logic [7:0] tx [8];
    int         npoll;
    tx = '{8'h03, v.addr[23:16], v.addr[15:8], v.addr[7:0], 8'h00, 8'h00, 8'h00, 8'h00};
    push(1'b1, 8'h10, 32'(CS_ID));
    push(1'b1, 8'h18, 32'd2);
    for (int i = 0; i < 8; i++) begin
      npoll = (i == 3) ? v.full_polls : 0;
      for (int p = 0; p < npoll; p++) push(1'b0, 8'h48, 32'h0);
      push(1'b0, 8'h48, 32'h0);
      push(1'b1, 8'h48, {24'h0, tx[i]});
    end
    npoll = v.rx_dead ? int'(POLL_MAX) : 8;
    for (int i = 0; i < npoll; i++) push(1'b0, 8'h4C, 32'h0);
    push(1'b1, 8'h18, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cnt;
    int hold_bad;
    cur_waits = v.waits;
    full_left = v.full_polls;
    tx_wr_cnt = 0;
    rx_idx    = 0;
    cur_rx    = v.rx;
    rx_dead   = v.rx_dead;
    sb_q.delete();
    build_expect(v);

    @(negedge PCLK);
    chk("req_ready_idle", {31'h0, ReqReady}, 32'h1);
    ReqValid = 1'b1;
    ReqAddr  = v.addr;
    @(negedge PCLK);
    ReqValid = 1'b0;
    ReqAddr  = ~v.addr;
    chk("req_ready_busy", {31'h0, ReqReady}, 32'h0);

    cnt = 0;
    while (RspValid !== 1'b1 && cnt < 20000) begin
      @(negedge PCLK);
      cnt++;
    end
    if (RspValid !== 1'b1) begin
      chk("rsp_timeout", {31'h0, RspValid}, 32'h1);
      return;
    end

    hold_bad = 0;
    if (v.stall > 0) begin
      ReqValid = 1'b1;
      ReqAddr  = 24'h0F0F0F;
      for (int i = 0; i < v.stall; i++) begin
        if (!(RspValid === 1'b1 && RspData === v.exp_data && RspErr === v.exp_err
              && ReqReady === 1'b0)) hold_bad++;
        @(negedge PCLK);
      end
      ReqValid = 1'b0;
      chk("rsp_hold", 32'(hold_bad), 32'h0);
    end

    chk($sformatf("rsp_data[%0d]", idx), RspData, v.exp_data);
    chk($sformatf("rsp_err[%0d]", idx), {31'h0, RspErr}, {31'h0, v.exp_err});
    RspReady = 1'b1;
    @(negedge PCLK);
    RspReady = 1'b0;
    chk("rsp_valid_drop", {31'h0, RspValid}, 32'h0);
    chk("req_ready_back", {31'h0, ReqReady}, 32'h1);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
  endtask

  task automatic reset_test();
    int cnt;
    int seen;
    mon_en    = 1'b0;
    cur_waits = 1000;
    sb_q.delete();
    @(negedge PCLK);
    ReqValid = 1'b1;
    ReqAddr  = 24'h777777;
    @(negedge PCLK);
    ReqValid = 1'b0;
    cnt = 0;
    while (!(PSEL === 1'b1 && PENABLE === 1'b1) && cnt < 50) begin
      @(negedge PCLK);
      cnt++;
    end
    chk("rst_in_access", {30'h0, PSEL, PENABLE}, 32'h3);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_psel_penable", {30'h0, PSEL, PENABLE}, 32'h0);
    chk("rst_req_ready", {31'h0, ReqReady}, 32'h1);
    @(negedge PCLK);
    cur_waits = 0;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_after_ready", {31'h0, ReqReady}, 32'h1);
    chk("rst_after_rsp", {30'h0, RspValid, RspErr}, 32'h0);
    seen = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (PSEL !== 1'b0) seen++;
    end
    chk("rst_no_replay", 32'(seen), 32'h0);
  endtask

  initial begin
    //          addr        rx (byte0 in [7:0])     full dead wait stall exp_data      err
    vecs[0] = '{24'h123456, 64'hDDCCBBAA_44332211, 0, 1'b0, 0, 0,  32'hDDCCBBAA, 1'b0};
    vecs[1] = '{24'hABCDEF, 64'h04030201_88776655, 3, 1'b0, 0, 0,  32'h04030201, 1'b0};
    vecs[2] = '{24'h000001, 64'h12345678_00000000, 0, 1'b0, 5, 0,  32'h12345678, 1'b0};
    vecs[3] = '{24'hFFFFFF, 64'hFF807F01_DEADBEEF, 0, 1'b0, 0, 10, 32'hFF807F01, 1'b0};
    vecs[4] = '{24'h5A5A5A, 64'h11111111_22222222, 0, 1'b1, 0, 0,  32'h00000000, 1'b1};
    vecs[5] = '{24'h00F00D, 64'hCAFEF00D_00000000, 3, 1'b0, 2, 3,  32'hCAFEF00D, 1'b0};

    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_apb_ctl", {29'h0, PSEL, PENABLE, PWRITE}, 32'h0);
    chk("reset_paddr", {24'h0, PADDR}, 32'h0);
    chk("reset_pwdata", PWDATA, 32'h0);
    chk("reset_rsp", {29'h0, RspValid, RspErr, ReqReady}, 32'h1);
    chk("reset_rspdata", RspData, 32'h0);
    chk("pstrb", {28'h0, PSTRB}, 32'hF);
    @(negedge PCLK);
    PRESETn = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    reset_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
